imem_dmem_arbiter: RTL and testbench

- Single-port unified memory arbiter for the RV32I 5-stage pipeline.
- Shares one synchronous memory between the IF-stage fetch port and the MEM-stage load/store port.
- Sequences each access through a fixed-latency FSM and generates the pipeline-wide stall.
- Sits between the pipeline registers (IF/ID, EX/MEM) and the memory macro; consumes IF_Flush from the main decoder.

---
 rtl/imem_dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter sharing one synchronous memory between IF fetch and MEM load/store.
// Optional feature macro ARB_STARVE_GUARD_EN: forces a fetch grant after STARVE_MAX back-to-back data grants.
module imem_dmem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ready,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic [31:0] o_d_rdata,
    output logic        o_d_ready,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
        $error("imem_dmem_arbiter: MEM_LAT and STARVE_MAX must lie in 1..15");
    end

    state_t      r_state;
    logic        r_owner_data;
    logic        r_cancel;
    logic [3:0]  r_cnt;
    logic        r_if_ready;
    logic        r_d_ready;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic w_idle;
    logic w_fetch_ok;
    logic w_grant_data;
    logic w_grant_fetch;
    logic w_cancel;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_fetch_ok = i_if_req & ~i_if_flush;
    assign w_cancel   = r_cancel | i_if_flush;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_starve;
    logic       w_force_fetch;

    assign w_force_fetch = w_fetch_ok & (r_starve >= 4'(STARVE_MAX));
    assign w_grant_data  = w_idle & i_d_req & ~w_force_fetch;

    // Count data grants that overtook a live fetch; any fetch grant or idle fetch port resets it.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_starve <= 4'd0;
        end else if (!i_if_req || w_grant_fetch) begin
            r_starve <= 4'd0;
        end else if (w_grant_data && w_fetch_ok) begin
            r_starve <= r_starve + 4'd1;
        end else begin
            r_starve <= r_starve;
        end
    end
`else
    assign w_grant_data = w_idle & i_d_req;
`endif

    assign w_grant_fetch = w_idle & w_fetch_ok & ~w_grant_data;

    // Access sequencer: grant, single-cycle strobe, latency wait, one-cycle ready pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_owner_data <= 1'b0;
            r_cancel     <= 1'b0;
            r_cnt        <= 4'd0;
            r_if_ready   <= 1'b0;
            r_d_ready    <= 1'b0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_mem_en   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cancel <= 1'b0;
                    if (w_grant_data || w_grant_fetch) begin
                        r_owner_data <= w_grant_data;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= w_grant_data & i_d_we;
                        r_mem_addr   <= w_grant_data ? i_d_addr : i_if_addr;
                        r_mem_wdata  <= w_grant_data ? i_d_wdata : 32'd0;
                        r_state      <= ST_ACCESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_cnt    <= LAT_LOAD;
                    r_cancel <= w_cancel;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cancel <= w_cancel;
                    if (r_cnt == 4'd0) begin
                        // A flushed fetch still finishes on the bus, but its data never reaches IF.
                        if (r_owner_data) begin
                            r_d_ready <= 1'b1;
                            r_d_rdata <= r_mem_we ? 32'd0 : i_mem_rdata;
                        end else if (!w_cancel) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end else begin
                            r_if_ready <= 1'b0;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_if_ready  = r_if_ready;
    assign o_d_ready   = r_d_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_stall     = i_reset & ((i_if_req & ~r_if_ready) | (i_d_req & ~r_d_ready));

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: directed test-plan cases plus random traffic against a memory/latency model.
module tb_imem_dmem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_if_flush;
    logic [31:0] o_if_rdata;
    logic        o_if_ready;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [31:0] o_d_rdata;
    logic        o_d_ready;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        o_stall;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_rdata(o_d_rdata), .o_d_ready(o_d_ready),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_stall(o_stall)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // Memory macro model: MEM_LAT-cycle read pipeline, garbage on the bus when no read is due.
    logic [31:0] phys_mem [256];
    bit          mem_init = 1'b1;
    int unsigned ncyc = 0;
    int unsigned en_count = 0;
    bit          rd_pend = 1'b0;
    int unsigned rd_due = 0;
    logic [31:0] rd_data;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_we;

    always @(negedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 256; k++) phys_mem[k] <= init_word(32'(k) << 2);
            rd_pend     <= 1'b0;
            i_mem_rdata <= 32'd0;
        end else begin
            i_mem_rdata <= (rd_pend && ncyc == rd_due) ? rd_data : $urandom();
            if (o_mem_en) begin
                en_count   <= en_count + 1;
                last_addr  <= o_mem_addr;
                last_we    <= o_mem_we;
                last_wdata <= o_mem_wdata;
                if (o_mem_we) begin
                    phys_mem[o_mem_addr[9:2]] <= o_mem_wdata;
                end else begin
                    rd_pend <= 1'b1;
                    rd_due  <= ncyc + MEM_LAT;
                    rd_data <= phys_mem[o_mem_addr[9:2]];
                end
            end
        end
        ncyc <= ncyc + 1;
    end

    // Protocol watch: a data request must stay up until its ready pulse.
    bit d_pend_q = 1'b0;
    always @(negedge clk) begin
        assert (!(d_pend_q && !i_d_req && i_reset))
            else $error("PROTOCOL: d_req dropped before d_ready");
        d_pend_q <= i_reset & i_d_req & ~o_d_ready;
    end

    logic [31:0] ref_mem [256];
    logic [31:0] grant_q [$];
    logic [31:0] exp_grants [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // One isolated transaction from an idle arbiter: checks latency, bus beat, data and stall.
    task automatic run_txn(input bit is_data, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
        int          lat;
        int unsigned en0;
        bit          done;
        logic [31:0] exp_data;
        logic [31:0] got;
        exp_data = (is_data && we) ? 32'd0 : ref_mem[addr[9:2]];
        if (is_data && we) ref_mem[addr[9:2]] = wdata;
        en0  = en_count;
        done = 1'b0;
        lat  = 0;
        got  = 32'd0;
        if (is_data) begin
            i_d_req = 1'b1; i_d_we = we; i_d_addr = addr; i_d_wdata = wdata;
        end else begin
            i_if_req = 1'b1; i_if_addr = addr;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            smp();
            if (is_data ? o_d_ready : o_if_ready) begin
                done = 1'b1;
                lat  = k;
                got  = is_data ? o_d_rdata : o_if_rdata;
                chk({tag, "_stall_at_ready"}, 32'(o_stall), 32'd0);
            end else begin
                chk({tag, "_stall_wait"}, 32'(o_stall), 32'd1);
                cyc();
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(MEM_LAT + 2));
        chk({tag, "_rdata"}, got, exp_data);
        chk({tag, "_mem_en_beats"}, en_count - en0, 32'd1);
        chk({tag, "_mem_addr"}, last_addr, addr);
        chk({tag, "_mem_we"}, 32'(last_we), 32'(is_data & we));
        if (is_data && we) chk({tag, "_mem_wdata"}, last_wdata, wdata);
        cyc();
        i_d_req  = 1'b0;
        i_if_req = 1'b0;
    endtask

    int          d_rdy_c, f_en_c, f_rdy_c, nrdy, nd;
    int unsigned en0;
    bit          f_done, dr, fr;
    logic [31:0] d_val, f_val, f_addr;
    int          exp_en [5]    = '{0, 1, 0, 0, 0};
    int          exp_rdy [5]   = '{0, 0, 0, 0, 1};
    int          exp_stall [5] = '{1, 1, 1, 1, 0};

    initial begin
        i_reset = 1'b0; i_if_req = 1'b0; i_if_addr = 32'd0; i_if_flush = 1'b0;
        i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = 32'd0; i_d_wdata = 32'd0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(32'(k) << 2);

        // Reset state
        cyc(); cyc(); cyc();
        smp();
        chk("rst_mem_en", 32'(o_mem_en), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_d_ready", 32'(o_d_ready), 32'd0);
        chk("rst_if_ready", 32'(o_if_ready), 32'd0);
        chk("rst_d_rdata", o_d_rdata, 32'd0);
        chk("rst_if_rdata", o_if_rdata, 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        mem_init = 1'b0;
        cyc();
        i_reset = 1'b1;
        cyc();

        // Single load, cycle-accurate
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            smp();
            chk($sformatf("load_c%0d_mem_en", k), 32'(o_mem_en), 32'(exp_en[k]));
            chk($sformatf("load_c%0d_d_ready", k), 32'(o_d_ready), 32'(exp_rdy[k]));
            chk($sformatf("load_c%0d_stall", k), 32'(o_stall), 32'(exp_stall[k]));
            if (k == 1) chk("load_mem_addr", o_mem_addr, 32'h100);
        end
        chk("load_d_rdata", o_d_rdata, 32'hDEAD_BEEF);
        cyc();
        i_d_req = 1'b0;

        // Store
        run_txn(1'b1, 1'b1, 32'h200, 32'h1234_5678, "store");

        // Collision: data first, fetch strobe two cycles after d_ready
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h40;
        i_if_req = 1'b1; i_if_addr = 32'h0;
        d_rdy_c = -1; f_en_c = -1; f_rdy_c = -1;
        d_val = 32'd0; f_val = 32'd0; f_addr = 32'hFFFF_FFFF;
        for (int c = 0; c < 24 && f_rdy_c < 0; c++) begin
            smp();
            if (o_mem_en && d_rdy_c >= 0 && f_en_c < 0) begin f_en_c = c; f_addr = o_mem_addr; end
            if (o_d_ready) begin d_rdy_c = c; d_val = o_d_rdata; end
            if (o_if_ready) begin f_rdy_c = c; f_val = o_if_rdata; end
            cyc();
            if (d_rdy_c == c) i_d_req = 1'b0;
        end
        i_if_req = 1'b0;
        chk("coll_d_ready_cycle", 32'(d_rdy_c), 32'(MEM_LAT + 2));
        chk("coll_d_rdata", d_val, ref_mem[32'h40 >> 2]);
        chk("coll_fetch_en_cycle", 32'(f_en_c), 32'(d_rdy_c + 2));
        chk("coll_fetch_addr", f_addr, 32'h0);
        chk("coll_if_ready_cycle", 32'(f_rdy_c), 32'(d_rdy_c + 2 + MEM_LAT + 1));
        chk("coll_if_rdata", f_val, ref_mem[0]);

        // Flush while the fetch waits on memory
        i_if_req = 1'b1; i_if_addr = 32'h80;
        en0 = en_count; nrdy = 0;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (o_if_ready) nrdy++;
            cyc();
            if (c == 1) begin i_if_flush = 1'b1; i_if_req = 1'b0; end
            if (c == 2) i_if_flush = 1'b0;
        end
        chk("flush_if_ready_pulses", 32'(nrdy), 32'd0);
        chk("flush_mem_en_beats", en_count - en0, 32'd1);
        run_txn(1'b1, 1'b0, 32'h100, 32'd0, "after_flush");

        // Reset during WAIT
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h104;
        cyc(); cyc();
        i_reset = 1'b0; i_d_req = 1'b0;
        smp();
        chk("midrst_mem_en", 32'(o_mem_en), 32'd0);
        chk("midrst_mem_addr", o_mem_addr, 32'd0);
        chk("midrst_d_rdata", o_d_rdata, 32'd0);
        chk("midrst_if_rdata", o_if_rdata, 32'd0);
        chk("midrst_d_ready", 32'(o_d_ready), 32'd0);
        cyc(); cyc();
        i_reset = 1'b1;
        nrdy = 0;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (o_d_ready || o_if_ready || o_mem_en) nrdy++;
            cyc();
        end
        chk("midrst_no_late_activity", 32'(nrdy), 32'd0);
        run_txn(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, "postrst_store");
        run_txn(1'b1, 1'b0, 32'h104, 32'd0, "postrst_load");

        // Continuous data pressure with a waiting fetch
        i_if_req = 1'b1; i_if_addr = 32'h10;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h180;
        nd = 0; f_done = 1'b0; f_val = 32'd0;
        grant_q.delete();
        for (int c = 0; c < 80 && !(nd == 3 && f_done); c++) begin
            smp();
            if (o_mem_en) grant_q.push_back(o_mem_addr);
            dr = o_d_ready;
            fr = o_if_ready;
            if (dr) nd++;
            if (fr) begin f_done = 1'b1; f_val = o_if_rdata; end
            cyc();
            if (dr) begin
                if (nd == 3) i_d_req = 1'b0;
                else i_d_addr = 32'h180 + 32'(nd * 4);
            end
            if (fr) i_if_req = 1'b0;
        end
        i_d_req = 1'b0; i_if_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        exp_grants = '{32'h180, 32'h184, 32'h10, 32'h188};
`else
        exp_grants = '{32'h180, 32'h184, 32'h188, 32'h10};
`endif
        chk("prio_grant_count", 32'(grant_q.size()), 32'd4);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("prio_grant%0d_addr", g), (g < grant_q.size()) ? grant_q[g] : 32'hFFFF_FFFF,
                exp_grants[g]);
        end
        chk("prio_if_rdata", f_val, ref_mem[32'h10 >> 2]);

        // Random traffic
        for (int t = 0; t < 30; t++) begin
            logic [31:0] ra;
            int          kind;
            repeat ($urandom_range(0, 2)) cyc();
            ra   = 32'($urandom_range(0, 255)) << 2;
            kind = $urandom_range(0, 2);
            case (kind)
                0: run_txn(1'b1, 1'b0, ra, 32'd0, $sformatf("rnd%0d_load", t));
                1: run_txn(1'b1, 1'b1, ra, $urandom(), $sformatf("rnd%0d_store", t));
                default: run_txn(1'b0, 1'b0, ra, 32'd0, $sformatf("rnd%0d_fetch", t));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
